// File: rtl/io_panel.sv
// io_panel: front-panel conditioner between board switches/LEDs and the core.
// Switch lines are synchronised, debounced and edge-detected per channel.
// LEDs are driven from a registered mux: off, direct, blink-gated, or switch mirror.
module io_panel #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLINK_DIV       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] switches,
    output logic [NUM_CH-1:0] sw_stable,
    output logic [NUM_CH-1:0] sw_rise,
    output logic [NUM_CH-1:0] sw_fall,
    input  logic [NUM_CH-1:0] led_data,
    input  logic [1:0]        led_mode,
    output logic [NUM_CH-1:0] LEDs
);

    // One extra bit so the terminal count always fits without wrapping.
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_DIRECT = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_MIRROR = 2'b11;

    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [CW-1:0]     cnt [NUM_CH];
    logic [BW-1:0]     blink_cnt;
    logic              phase;

    // Two-flop synchroniser for the asynchronous switch levels.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switches;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce: a new level must differ for DEBOUNCE_CYCLES edges
    // in a row; any return to the accepted level restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_stable <= '0;
            sw_rise   <= '0;
            sw_fall   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                sw_rise[i] <= 1'b0;
                sw_fall[i] <= 1'b0;
                if (sync2[i] == sw_stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    sw_stable[i] <= sync2[i];
                    sw_rise[i]   <= sync2[i];
                    sw_fall[i]   <= ~sync2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Free-running blink divider; phase flips each time the counter wraps.
    // Deliberately independent of led_mode so mode changes keep the rhythm.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Registered LED drive selected by led_mode.
    always_ff @(posedge clock) begin
        if (reset) begin
            LEDs <= '0;
        end else begin
            case (led_mode)
                MODE_OFF:    LEDs <= '0;
                MODE_DIRECT: LEDs <= led_data;
                MODE_BLINK:  LEDs <= led_data & {NUM_CH{phase}};
                MODE_MIRROR: LEDs <= sw_stable;
                default:     LEDs <= '0;
            endcase
        end
    end

endmodule
